// File: rtl/accel_host_seq_if.sv
// Host command/response channel, accelerator memory bus and done/busy status for accel_host_seq.
// The slave modport is the sequencer's view; master is the host/memory side.
interface accel_host_seq_if #(
  parameter int INT_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH     = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [INT_ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_data;
  logic                      rsp_err;

  logic                      mem_req;
  logic                      mem_we;
  logic [INT_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  logic                      done_i;
  logic                      busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  rsp_ready, mem_rdata, done_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output rsp_ready, mem_rdata, done_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
  );
endinterface

// File: rtl/accel_host_seq.sv
// One-command-at-a-time host sequencer: WRITE/READ bus accesses, RUN = ctrl write, wait done, status read.
// Response held until rsp_ready; optional RUN done-wait timeout via ACCEL_HOST_SEQ_TIMEOUT_EN.
module accel_host_seq #(
  parameter int                        INT_ADDR_WIDTH = 20,
  parameter int                        DATA_WIDTH     = 32,
  parameter logic [INT_ADDR_WIDTH-1:0] CTRL_ADDR      = 'h0,
  parameter logic [INT_ADDR_WIDTH-1:0] STAT_ADDR      = 'h8,
  parameter int                        TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           rst,
  accel_host_seq_if.slave bus
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [INT_ADDR_WIDTH-1:0] ADDR_MASK = {INT_ADDR_WIDTH{1'b1}} << OFF_W;
  localparam logic [DATA_WIDTH-1:0] START_BIT = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_RUN   = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_START,
    S_WAIT_DONE,
    S_ST_REQ,
    S_ST_WAIT,
    S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [INT_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;

  logic                      cmd_ready_c;
  logic                      mem_req_c;
  logic                      mem_we_c;
  logic [INT_ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0]     mem_wdata_c;

`ifdef ACCEL_HOST_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cmd_ready_c = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
`ifdef ACCEL_HOST_SEQ_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          addr_d     = bus.cmd_addr;
          wdata_d    = bus.cmd_wdata;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (op_t'(bus.cmd_op))
            OP_WRITE: state_d = S_WR;
            OP_READ:  state_d = S_RD_REQ;
            OP_RUN:   state_d = S_START;
            default: begin
              rsp_err_d = 1'b1;
              state_d   = S_RESP;
            end
          endcase
        end
      end

      S_WR: begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = addr_q;
        mem_wdata_c = wdata_q;
        state_d     = S_RESP;
      end

      S_RD_REQ: begin
        mem_req_c  = 1'b1;
        mem_addr_c = addr_q;
        state_d    = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        rsp_data_d = bus.mem_rdata;
        state_d    = S_RESP;
      end

      // done_i is deliberately not looked at here; the accelerator is only kicked this cycle
      S_START: begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = CTRL_ADDR;
        mem_wdata_c = wdata_q | START_BIT;
        state_d     = S_WAIT_DONE;
`ifdef ACCEL_HOST_SEQ_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end

      S_WAIT_DONE: begin
`ifdef ACCEL_HOST_SEQ_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.done_i) begin
          state_d = S_ST_REQ;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RESP;
        end
`else
        if (bus.done_i) begin
          state_d = S_ST_REQ;
        end
`endif
      end

      S_ST_REQ: begin
        mem_req_c  = 1'b1;
        mem_addr_c = STAT_ADDR;
        state_d    = S_ST_WAIT;
      end

      S_ST_WAIT: begin
        rsp_data_d = bus.mem_rdata;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_c & ~rst;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c & ADDR_MASK;
  assign bus.mem_be    = mem_req_c ? {BE_W{1'b1}} : {BE_W{1'b0}};
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_accel_host_seq.sv
// Bench for accel_host_seq: directed cases plus randomized commands against a transaction-level model.
module tb_accel_host_seq;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [19:0] CTRL = 20'h0;
  localparam logic [19:0] STAT = 20'h8;
  localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_RUN = 2'd2, OP_RSV = 2'd3;

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int idle_bad = 0;
  logic [31:0] status_val = 32'h0;

  logic [31:0]   dev_mem [1024];
  logic [1023:0] dev_vld = '0;
  logic [31:0]   ref_mem [1024];
  logic [1023:0] ref_vld = '0;
  acc_t acc_q[$];

  always #5 clk = ~clk;

  accel_host_seq_if #(.INT_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  accel_host_seq #(
    .INT_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CTRL_ADDR(CTRL), .STAT_ADDR(STAT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  function automatic logic [31:0] init_val(input logic [19:0] a);
    return ({12'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory device: read data appears the cycle after the request, junk otherwise
  always @(posedge clk) begin
    if (!rst && bus.mem_req) begin
      acc_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_we ? bus.mem_wdata : 32'h0});
      if (bus.mem_we) begin
        dev_mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        dev_vld[bus.mem_addr[11:2]] <= 1'b1;
        bus.mem_rdata <= $urandom;
      end else if (bus.mem_addr == STAT) begin
        bus.mem_rdata <= status_val;
      end else begin
        bus.mem_rdata <= dev_vld[bus.mem_addr[11:2]] ? dev_mem[bus.mem_addr[11:2]] : init_val(bus.mem_addr);
      end
    end else begin
      bus.mem_rdata <= $urandom;
    end
    if (!rst && !bus.mem_req && (bus.mem_we || bus.mem_addr != 0 || bus.mem_wdata != 0 || bus.mem_be != 0))
      idle_bad <= idle_bad + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [19:0] a);
    return ref_vld[a[11:2]] ? ref_mem[a[11:2]] : init_val(a);
  endfunction

  task automatic ref_wr(input logic [19:0] a, input logic [31:0] d);
    ref_mem[a[11:2]] = d;
    ref_vld[a[11:2]] = 1'b1;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [19:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 20'($urandom);
    bus.cmd_wdata = $urandom;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [19:0] a, input logic [31:0] wd,
                        input int dd, input int rd,
                        output int lat, output logic [31:0] d, output logic e);
    issue_cmd(op, a, wd);
    lat = 0;
    d = 32'h0;
    e = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
      bus.done_i = (n == dd);
    end
    bus.done_i = 1'b0;
    if (lat == 0) return;
    d = bus.rsp_data;
    e = bus.rsp_err;
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_data", 64'(bus.rsp_data), 64'(d));
      chk("hold_err", 64'(bus.rsp_err), 64'(e));
      chk("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_rsp_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
  endtask

  // Predict bus accesses, response and latency from the command semantics, then run and compare
  task automatic check_cmd(input logic [1:0] op, input logic [19:0] a, input logic [31:0] wd,
                           input int dd, input int rd, output logic [31:0] d, output logic e);
    acc_t exp_q[$];
    logic [31:0] exp_d;
    logic exp_e;
    int exp_lat;
    int lat;
    logic [19:0] aa;
    aa = a & 20'hFFFFC;
    exp_d = 32'h0;
    exp_e = 1'b0;
    exp_lat = 1;
    case (op)
      OP_WR: begin
        exp_q.push_back({1'b1, aa, 4'hF, wd});
        ref_wr(aa, wd);
        exp_lat = 2;
      end
      OP_RD: begin
        exp_q.push_back({1'b0, aa, 4'hF, 32'h0});
        exp_d = ref_rd(aa);
        exp_lat = 3;
      end
      OP_RUN: begin
        exp_q.push_back({1'b1, CTRL, 4'hF, wd | 32'h1});
        ref_wr(CTRL, wd | 32'h1);
        if (dd == 0) begin
          exp_e = 1'b1;
          exp_lat = TO + 2;
        end else begin
          exp_q.push_back({1'b0, STAT, 4'hF, 32'h0});
          exp_d = status_val;
          exp_lat = dd + 3;
        end
      end
      default: begin
        exp_e = 1'b1;
        exp_lat = 1;
      end
    endcase
    acc_q.delete();
    do_cmd(op, a, wd, dd, rd, lat, d, e);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rsp_data", 64'(d), 64'(exp_d));
    chk("rsp_err", 64'(e), 64'(exp_e));
    chk("n_access", 64'(acc_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk("access", 64'(acc_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic e;
    logic [1:0] op;
    logic [19:0] a;
    logic [31:0] wd;
    int dd;

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.done_i = 1'b0;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_bus", 64'({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rel_rsp", 64'({bus.rsp_err, bus.rsp_data}), 64'd0);

    check_cmd(OP_WR, 20'h80010, 32'hDEADBEEF, 0, 0, d, e);
    chk("spec_wr_data", 64'(d), 64'd0);
    check_cmd(OP_WR, 20'h80010, 32'h12345678, 0, 0, d, e);
    check_cmd(OP_RD, 20'h80013, 32'h0, 0, 0, d, e);
    chk("spec_rd_data", 64'(d), 64'h12345678);

    status_val = 32'h0000_0002;
    check_cmd(OP_RUN, 20'h0, 32'h2000, 10, 0, d, e);
    chk("spec_run_data", 64'(d), 64'h2);

    check_cmd(OP_RSV, 20'h123, 32'hFFFF, 0, 0, d, e);
    check_cmd(OP_RD, 20'h104, 32'h0, 0, 5, d, e);

`ifdef ACCEL_HOST_SEQ_TIMEOUT_EN
    check_cmd(OP_RUN, 20'h0, 32'h0077, 0, 0, d, e);
`endif

    // Reset while waiting for done: no response may follow, next command runs normally
    acc_q.delete();
    issue_cmd(OP_RUN, 20'h0, 32'h0030);
    ref_wr(CTRL, 32'h0031);
    repeat (5) @(negedge clk);
    chk("wait_busy", 64'(bus.busy), 64'd1);
    chk("wait_no_rsp", 64'(bus.rsp_valid), 64'd0);
`ifndef ACCEL_HOST_SEQ_TIMEOUT_EN
    repeat (35) @(negedge clk);
    chk("hang_busy", 64'(bus.busy), 64'd1);
    chk("hang_no_rsp", 64'(bus.rsp_valid), 64'd0);
`endif
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check_cmd(OP_RD, 20'h80013, 32'h0, 0, 0, d, e);

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a = 20'h100 + 20'($urandom_range(0, 63));
      wd = $urandom;
      dd = (op == OP_RUN) ? $urandom_range(2, 12) : 0;
      status_val = $urandom;
      check_cmd(op, a, wd, dd, $urandom_range(0, 3), d, e);
    end

    chk("idle_bus_zero", 64'(idle_bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
